// File: rtl/seg_serial_driver.sv
// Hex-to-seven-segment decode for DIGITS digits, serialised MSB first onto an
// external shift-register chain with a generated seg_clk, then latched via seg_pen.
module seg_serial_driver #(
  parameter int DIGITS     = 8,
  parameter int CLK_DIV    = 4,
  parameter int BLINK_BITS = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   hexs,
  input  logic [DIGITS-1:0]     points,
  input  logic [DIGITS-1:0]     LEs,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  seg_clk,
  output logic                  seg_sout,
  output logic                  seg_pen,
  output logic                  seg_clrn
);

  localparam int NBITS = 8 * DIGITS;
  localparam int BCW   = $clog2(NBITS + 1);
  localparam int DCW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(NBITS - 1);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

  state_t                  state;
  logic [BLINK_BITS-1:0]   blink_cnt;
  logic [DCW-1:0]          div_cnt;
  logic [BCW-1:0]          bit_cnt;
  logic [NBITS-1:0]        frame;
  logic [NBITS-1:0]        frame_next;
  logic [4*DIGITS-1:0]     cap_hexs;
  logic [DIGITS-1:0]       cap_points;
  logic [DIGITS-1:0]       cap_les;
  logic [DIGITS-1:0]       cap_blink;
  logic                    cap_phase;
  logic                    half_end;

  // Segment order {a,b,c,d,e,f,g,p}, active-low, point off.
  function automatic logic [7:0] hex_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_seg = 8'h03;  4'h1: hex_seg = 8'h9F;
      4'h2: hex_seg = 8'h25;  4'h3: hex_seg = 8'h0D;
      4'h4: hex_seg = 8'h99;  4'h5: hex_seg = 8'h49;
      4'h6: hex_seg = 8'h41;  4'h7: hex_seg = 8'h1F;
      4'h8: hex_seg = 8'h01;  4'h9: hex_seg = 8'h09;
      4'hA: hex_seg = 8'h11;  4'hB: hex_seg = 8'hC1;
      4'hC: hex_seg = 8'h63;  4'hD: hex_seg = 8'h85;
      4'hE: hex_seg = 8'h61;  default: hex_seg = 8'h71;
    endcase
  endfunction

  always_comb begin
    logic [7:0] seg_byte;
    // NOTE: every variable gets a default first so no path can infer a latch.
    frame_next = '0;
    seg_byte   = 8'hFF;
    for (int i = 0; i < DIGITS; i++) begin
      seg_byte = hex_seg(cap_hexs[4*i +: 4]);
      if (cap_points[i]) seg_byte[0] = 1'b0;
      if (cap_les[i] || (cap_blink[i] && cap_phase)) seg_byte = 8'hFF;
      frame_next[8*i +: 8] = seg_byte;
    end
  end

  assign half_end = (div_cnt == DIV_LAST);

  // NOTE: datapath registers carry no reset; control decides when they are meaningful.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      cap_hexs   <= hexs;
      cap_points <= points;
      cap_les    <= LEs;
      cap_blink  <= blink;
      cap_phase  <= blink_cnt[BLINK_BITS-1];
    end
    if (state == LOAD)
      frame <= frame_next;
    else if (state == SHIFT && half_end && seg_clk)
      frame <= {frame[NBITS-2:0], 1'b0};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      seg_clk   <= 1'b0;
      seg_sout  <= 1'b0;
      seg_pen   <= 1'b1;
      seg_clrn  <= 1'b0;
      blink_cnt <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
    end else begin
      seg_clrn  <= 1'b1;
      blink_cnt <= blink_cnt + BLINK_BITS'(1);
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          seg_sout <= frame_next[NBITS-1];
          seg_pen  <= 1'b0;
          seg_clk  <= 1'b0;
          div_cnt  <= '0;
          bit_cnt  <= '0;
          state    <= SHIFT;
        end
        SHIFT: begin
          if (half_end) begin
            div_cnt <= '0;
            if (!seg_clk) begin
              seg_clk <= 1'b1;
            end else begin
              seg_clk <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                state <= LATCH;
              end else begin
                bit_cnt  <= bit_cnt + BCW'(1);
                seg_sout <= frame[NBITS-2];
              end
            end
          end else begin
            div_cnt <= div_cnt + DCW'(1);
          end
        end
        LATCH: begin
          if (half_end) begin
            div_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            seg_pen <= 1'b1;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + DCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_serial_driver.sv
// Directed bench for seg_serial_driver: captures the rising-edge serial stream
// and compares frames, handshake timing and reset behaviour against hand values.
module tb_seg_serial_driver;

  localparam int DIGITS     = 8;
  localparam int CLK_DIV    = 2;
  localparam int BLINK_BITS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] hexs;
  logic [7:0]  points, les, blink;
  logic        start;
  logic        busy, done, seg_clk, seg_sout, seg_pen, seg_clrn;

  int n_checks = 0;
  int n_fail   = 0;

  seg_serial_driver #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLINK_BITS(BLINK_BITS)) dut (
    .clk(clk), .rst(rst), .hexs(hexs), .points(points), .LEs(les), .blink(blink),
    .start(start), .busy(busy), .done(done), .seg_clk(seg_clk), .seg_sout(seg_sout),
    .seg_pen(seg_pen), .seg_clrn(seg_clrn)
  );

  always #5 clk = ~clk;

  // Independent model of the free-running blink counter.
  logic [BLINK_BITS-1:0] m_cnt = '0;
  always @(posedge clk) m_cnt <= rst ? '0 : m_cnt + 4'd1;

  // Receiver model: shift in seg_sout on every rising seg_clk.
  logic         prev_sclk = 1'b0;
  int           nbits = 0;
  logic [127:0] stream = '0;
  always @(negedge clk) begin
    if (seg_clk && !prev_sclk) begin
      stream = {stream[126:0], seg_sout};
      nbits++;
    end
    prev_sclk = seg_clk;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_bits(input int n);
    for (int k = 0; k < 2000 && nbits < n; k++) @(negedge clk);
  endtask

  task automatic run_frame(input logic [31:0] h, input logic [7:0] p, input logic [7:0] l,
                           input logic [7:0] b, input bit use_phase, input bit phase,
                           input logic [63:0] exp, input string tag);
    int cyc, pen_low;
    bit seen;
    @(negedge clk);
    hexs = h; points = p; les = l; blink = b;
    for (int k = 0; k < 40 && use_phase && m_cnt[BLINK_BITS-1] != phase; k++) @(negedge clk);
    nbits = 0; stream = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; pen_low = 0; seen = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (done) begin seen = 1'b1; break; end
      if (busy) cyc++;
      if (!seg_pen) pen_low++;
      @(negedge clk);
    end
    check({tag, "_done"}, 128'(seen), 128'(1));
    check({tag, "_stream"}, 128'(stream[63:0]), 128'(exp));
    if (tag == "basic") begin
      check("basic_busy_cycles", 128'(cyc), 128'(259));
      check("basic_pen_low", 128'(pen_low), 128'(258));
      check("basic_nbits", 128'(nbits), 128'(64));
      check("basic_done_busy", 128'(busy), 128'(0));
      check("basic_done_pen", 128'(seg_pen), 128'(1));
      @(negedge clk);
      check("basic_done_pulse", 128'(done), 128'(0));
    end
  endtask

  initial begin
    int  busy_seen;
    int  done_seen;
    bit  seen;
    rst = 1'b1; start = 1'b0; hexs = '0; points = '0; les = '0; blink = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_sclk", 128'(seg_clk), 128'(0));
    check("rst_sout", 128'(seg_sout), 128'(0));
    check("rst_pen", 128'(seg_pen), 128'(1));
    check("rst_clrn", 128'(seg_clrn), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    check("clrn_run", 128'(seg_clrn), 128'(1));

    run_frame(32'h1000_0000, 8'h00, 8'h00, 8'h00, 0, 0, 64'h9F03_0303_0303_0303, "basic");
    run_frame(32'h1000_0000, 8'hFF, 8'hFF, 8'h00, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, "blank");
    run_frame(32'h0000_0000, 8'h80, 8'h00, 8'h00, 0, 0, 64'h0203_0303_0303_0303, "point");
    run_frame(32'h89AB_CDEF, 8'h00, 8'h00, 8'h00, 0, 0, 64'h0109_11C1_6385_6171, "sweep_hi");
    run_frame(32'h0123_4567, 8'h00, 8'h00, 8'h00, 0, 0, 64'h039F_250D_9949_411F, "sweep_lo");
    run_frame(32'h0000_0000, 8'h00, 8'h00, 8'h01, 1, 1, 64'h0303_0303_0303_03FF, "blink_on");
    run_frame(32'h0000_0000, 8'h00, 8'h00, 8'h01, 1, 0, 64'h0303_0303_0303_0303, "blink_off");

    // Start held high: back-to-back frames, capture in the done cycle, inputs changed mid-SHIFT.
    @(negedge clk);
    hexs = 32'h1000_0000; points = '0; les = '0; blink = '0;
    nbits = 0; stream = '0; start = 1'b1;
    wait_bits(30);
    hexs = 32'hFFFF_FFFF;
    wait_done(seen);
    check("hs_done1", 128'(seen), 128'(1));
    check("hs_done_busy", 128'(busy), 128'(0));
    @(negedge clk);
    check("hs_accept", 128'(busy), 128'(1));
    wait_bits(94);
    start = 1'b0;
    wait_done(seen);
    check("hs_done2", 128'(seen), 128'(1));
    busy_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check("hs_no_third", 128'(busy_seen), 128'(0));
    check("hs_nbits", 128'(nbits), 128'(128));
    check("hs_stream", stream, {64'h9F03_0303_0303_0303, 64'h7171_7171_7171_7171});

    // Reset at bit 20 of a frame.
    @(negedge clk);
    hexs = 32'h1000_0000; nbits = 0; stream = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_bits(20);
    check("mid_reach", 128'(nbits), 128'(20));
    rst = 1'b1;
    @(negedge clk);
    check("mid_busy", 128'(busy), 128'(0));
    check("mid_sclk", 128'(seg_clk), 128'(0));
    check("mid_pen", 128'(seg_pen), 128'(1));
    check("mid_clrn", 128'(seg_clrn), 128'(0));
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 300; k++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    check("mid_no_done", 128'(done_seen), 128'(0));
    run_frame(32'h1000_0000, 8'h00, 8'h00, 8'h00, 0, 0, 64'h9F03_0303_0303_0303, "basic");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_serial_driver.md
Name: seg_serial_driver

Overview:
- Parametrised successor to the team's parallel hex-to-seven-segment decode.
- Decodes DIGITS hex nibbles into active-low segment bytes, with per-digit decimal point, per-digit blanking and per-digit blink.
- Serialises the resulting 8*DIGITS-bit frame to the board's external segment shift-register chain using a generated serial clock, then latches it.
- Sits between display-value logic (score/state) and the board display pins.
- Driven by a one-cycle start strobe with busy/done handshake.

Parameters:
- DIGITS, 8, number of seven-segment digits (≥1).
- CLK_DIV, 4, clk cycles per seg_clk half-period (≥1).
- BLINK_BITS, 24, width of the free-running blink counter; its MSB is the blink phase.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- hexs  input  4*DIGITS  digit values; most-significant nibble is the leftmost digit.
- points  input  DIGITS  decimal-point enable per digit; bit i pairs with nibble i.
- LEs  input  DIGITS  blank enable per digit (1 = digit fully dark).
- blink  input  DIGITS  blink enable per digit.
- start  input  1  one-cycle request to capture the inputs and send a frame.
- busy  output  1  frame transfer in progress.
- done  output  1  one-cycle pulse when the frame has been latched.
- seg_clk  output  1  serial shift clock to the display chain.
- seg_sout  output  1  serial data to the display chain.
- seg_pen  output  1  display output enable; 0 while shifting.
- seg_clrn  output  1  active-low clear to the display chain.

Behaviour:
- Reset values (rst=1 at an edge): state IDLE, busy=0, done=0, seg_clk=0, seg_sout=0, seg_pen=1, seg_clrn=0, blink counter=0. seg_clrn is 1 in every non-reset cycle.
- Segment byte for each digit: {a,b,c,d,e,f,g,p}, active-low (0 = lit).
  - Hex decode: 0→03, 1→9F, 2→25, 3→0D, 4→99, 5→49, 6→41, 7→1F, 8→01, 9→09, A→11, b→C1, C→63, d→85, E→61, F→71. All values are hex with p=1.
  - point=1 clears bit 0 (p).
  - Blanked digit = 8'hFF, including p. This overrides point.
  - A digit is blanked if LEs[i]=1, or if blink[i]=1 and blink phase=1 at capture.
- Frame layout: byte [8i+7:8i] = segment byte for nibble hexs[4i+3:4i].
- Blink counter increments every clk cycle and wraps modulo 2^BLINK_BITS.
- States: IDLE → LOAD → SHIFT → LATCH → IDLE.
- IDLE:
  - start=1 captures hexs/points/LEs/blink and the blink phase. Next state is LOAD.
  - start is also accepted in the same cycle that done pulses.
- LOAD (1 cycle): decode captured values into the 8*DIGITS frame register. busy=1 from this cycle onward.
- SHIFT:
  - Bits are sent MSB first (bit 8*DIGITS-1 first, bit 0 last).
  - Per bit: seg_sout presents the bit while seg_clk=0 for CLK_DIV cycles, then seg_clk=1 for CLK_DIV cycles. The receiver samples on the rising edge.
  - seg_pen=0 throughout SHIFT.
  - Duration: 16*DIGITS*CLK_DIV cycles.
  - A bit counter of width clog2(8*DIGITS+1) ends SHIFT after the last high half-period.
- LATCH: CLK_DIV cycles with seg_clk=0 and seg_pen=0. Then IDLE.
- First IDLE cycle after LATCH: done=1 for one cycle, seg_pen=1, busy=0.
- busy is high for exactly 1 + 16*DIGITS*CLK_DIV + CLK_DIV cycles.
- start while busy is ignored. No queueing.
- Input changes after capture do not affect the frame in flight.
- rst mid-frame: abort immediately to reset values. No done pulse. A partial frame may remain in the chain; it is cleared via seg_clrn.

Test Plan (DIGITS=8, CLK_DIV=2, BLINK_BITS=4):
- Basic frame: hexs=32'h1000_0000, points=0, LEs=0, blink=0, start pulse.
  - Sampled rising-edge stream is 9F then 03 ×7 (MSB first).
  - busy high exactly 259 cycles; done pulses at cycle 260.
- Blanking and point: LEs=8'hFF, points=8'hFF → 64 ones.
  - Then LEs=0, points=8'h80, hexs=0 → first byte 02, rest 03.
- Full decode sweep: hexs=32'h89AB_CDEF, then 32'h0123_4567 → bytes match the decode table in order.
- Blink: blink=8'h01, hexs=0, start when blink counter MSB=1 → last byte FF.
  - Start when MSB=0 → last byte 03.
- Handshake: start held high across a whole frame → exactly one frame per IDLE entry.
  - Frames run back-to-back, with start accepted in the done cycle.
  - A change to hexs mid-SHIFT does not alter the stream.
- Reset mid-SHIFT at bit 20: next cycle busy=0, seg_clk=0, seg_pen=1, seg_clrn=0, no done pulse.
  - After rst drops, a new start produces a correct full frame.
